dmem_bus_ctrl: RTL
==================

# dmem_bus_ctrl

Data-memory bus controller sitting directly downstream of the memory-stage byte-lane logic. Takes the lane-replicated store data, byte enables and address produced in the M stage, runs one word transaction on an external req/ack memory bus, and returns the raw 32-bit read word for lane extraction. Stalls the pipeline for the transaction's duration and flags bus timeouts.

## Interface
- `TIMEOUT`, default 255: cycles `bus_req` may stay high without `bus_ack` before the access is abandoned; legal range 1..255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_read_M` input 1: M-stage load request.
- `mem_write_M` input 1: M-stage store request.
- `alu_out_M` input 32: byte address; bits [1:0] are dropped on the bus.
- `mem_in_M` input 32: lane-replicated store data.
- `byte_en_M` input 4: store byte enables.
- `mem_out_M` output 32: registered raw read word.
- `stall_mem` output 1: pipeline freeze, combinational.
- `bus_err` output 1: sticky timeout flag.
- `bus_req` output 1: registered bus request.
- `bus_we` output 1: registered; 1 = write.
- `bus_addr` output 32: registered; {alu_out_M[31:2], 2'b00}.
- `bus_wdata` output 32: registered store data.
- `bus_be` output 4: registered; byte_en_M on writes, 4'b1111 on reads.
- `bus_ack` input 1: slave completion, sampled on `clk`.
- `bus_rdata` input 32: read data, valid when `bus_ack`=1 on a read.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if `mem_read_M` or `mem_write_M`, latch the bus fields, set `bus_req`, clear the timeout counter, go to REQ. Otherwise stay.
- Both strobes high is illegal. The write wins and the read is ignored.
- REQ: hold `bus_req` and all bus fields stable.
  - If `bus_ack`: on a read, capture `bus_rdata` into `mem_out_M`. Drop `bus_req` and go to DONE.
  - Else increment the counter. When the counter reaches `TIMEOUT`: drop `bus_req`, set `bus_err`, load `mem_out_M` with 0, go to DONE.
- DONE: always go to IDLE. There is no re-trigger from DONE, because M-stage inputs still belong to the completed instruction in that cycle.
- Writes never modify `mem_out_M`. It holds the last read word.
- `bus_err` is cleared only by `reset`.
- `bus_ack` seen in IDLE or DONE is ignored.
- `stall_mem` = (state==IDLE and (`mem_read_M` or `mem_write_M`)) or state==REQ.

## Timing
- Reset values:
  - state IDLE; counter 0.
  - `bus_req` 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0, `bus_be` 0.
  - `mem_out_M` 0, `bus_err` 0.
  - `stall_mem` is combinational; it reads 0 in IDLE with no request.
- Load issued in cycle N (IDLE):
  - `stall_mem` high in N.
  - `bus_req` high from N+1.
  - If ack arrives in cycle K, `mem_out_M` is valid and `stall_mem` is low in K+1 (DONE).
- Zero-wait slave (ack in N+1): 2 stall cycles (N, N+1); data in N+2.
- Timeout: `bus_req` is high for exactly `TIMEOUT`+1 cycles. `bus_err` rises in the DONE cycle.
- Ack in the same cycle the counter hits `TIMEOUT`: the ack wins and `bus_err` is not set.
- Reset mid-REQ: `bus_req` is low the cycle after the reset edge. The transaction is abandoned silently and `bus_err` is cleared.
- Back-to-back accesses: state is IDLE one cycle after DONE. The next access then sees the same stall pattern from its own cycle N.

## Structure
- Shared package `mips_pkg`: state enum `dmem_state_t` (IDLE/REQ/DONE), `WORD_BYTES`=4, `BE_ALL`=4'b1111, `TIMEOUT_RESET_DATA`=32'h0.
- One natural sub-module: `timeout_counter` (8-bit, synchronous clear, enable, terminal-count output against `TIMEOUT`).
- The FSM and bus registers stay in `dmem_bus_ctrl`.

## Test plan
- **Reset:** hold `reset` 2 cycles mid-REQ. Expect `bus_req`=0 the next cycle, all outputs at reset values, `stall_mem`=0.
- **Zero-wait load:** `mem_read_M`=1, `alu_out_M`=32'h0000_1006, ack in N+1 with `bus_rdata`=32'hCAFE_F00D. Expect:
  - `bus_addr`=32'h0000_1004 and `bus_be`=4'hF.
  - `stall_mem` high for exactly 2 cycles.
  - `mem_out_M`=32'hCAFE_F00D in N+2.
- **Byte store with wait states:** `mem_write_M`=1, `mem_in_M`=32'hABAB_ABAB, `byte_en_M`=4'b0100, ack after 3 wait cycles. Expect:
  - `bus_we`=1 and `bus_be`=4'b0100, stable throughout REQ.
  - `mem_out_M` unchanged.
- **Timeout with `TIMEOUT`=4, no ack:** expect `bus_req` high 5 cycles, then `bus_err`=1, `mem_out_M`=0, `stall_mem` low in DONE. `bus_err` stays 1 across later successful loads.
- **Edge cases:** ack exactly at the terminal count gives `bus_err`=0 and data captured. Both strobes high produces a write only.
- **Back-to-back:** load then store with zero-wait acks. Expect 2 stall cycles each, one non-stalled DONE cycle between them, and no duplicate `bus_req`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data-memory bus FSM states and bus constants.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_t;

  localparam int unsigned WORD_BYTES         = 4;
  localparam logic [3:0]  BE_ALL             = 4'b1111;
  localparam logic [31:0] TIMEOUT_RESET_DATA = 32'h0;

  // Clear the byte-offset bits so the bus always sees a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/dmem_bus_ctrl_timeout_counter.sv
// 8-bit wait-cycle counter with synchronous clear/enable and a terminal-count flag.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == 8'(TIMEOUT));

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: one word transaction per M-stage access on a req/ack bus,
// stalling the pipeline until completion and flagging timeouts with a sticky error.
module dmem_bus_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [31:0] alu_out_M,
  input  logic [31:0] mem_in_M,
  input  logic [3:0]  byte_en_M,
  output logic [31:0] mem_out_M,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  dmem_state_t state;
  logic        access;
  logic        tc;
  logic        cnt_clr;
  logic        cnt_en;

  assign access = mem_read_M || mem_write_M;

  always_comb begin
    stall_mem = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    if (state == IDLE) begin
      stall_mem = access;
      cnt_clr   = access;
    end else if (state == REQ) begin
      stall_mem = 1'b1;
      cnt_en    = !bus_ack && !tc;
    end
  end

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      mem_out_M <= '0;
      bus_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            // A write with both strobes set wins; the read is dropped.
            state     <= REQ;
            bus_req   <= 1'b1;
            bus_we    <= mem_write_M;
            bus_addr  <= word_align(alu_out_M);
            bus_wdata <= mem_in_M;
            bus_be    <= mem_write_M ? byte_en_M : BE_ALL;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (bus_ack) begin
            if (!bus_we) begin
              mem_out_M <= bus_rdata;
            end
            bus_req <= 1'b0;
            state   <= DONE;
          end else if (tc) begin
            bus_req   <= 1'b0;
            bus_err   <= 1'b1;
            mem_out_M <= TIMEOUT_RESET_DATA;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
